// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter
//   Round-robin arbiter that owns the select line of a shared 4:1 data mux.
//   Each ownership lasts at most MAX_HOLD cycles so that no requester can starve.
//   When the owner releases, the rotation pointer moves just past it. The
//   arbiter then re-arbitrates in the same cycle, so grants go back-to-back.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high
//   req    in   [3:0] request vector, held high while a requester wants the mux
//   in     in   [4*WIDTH-1:0] data lanes, lane i = in[i*WIDTH +: WIDTH]
//   gnt    out  [3:0] registered one-hot grant, zero when idle
//   s      out  [1:0] registered mux select (index of the granted lane)
//   valid  out  registered, high while a grant is active
//   out    out  [WIDTH-1:0] selected lane when valid, else zero
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no grant outstanding; arbitrate from ptr whenever req != 0
// ST_BUSY | lane s owns the mux; hold_cnt counts cycles of ownership
module rr_mux4_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] in,
  output logic [3:0]         gnt,
  output logic [1:0]         s,
  output logic               valid,
  output logic [WIDTH-1:0]   out
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_s, w_s_nxt;
  logic       r_valid, w_valid_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_hold_cnt, w_hold_nxt;
  logic [2:0] w_arb;
  logic [1:0] w_s_inc;

  // {found, index}. Scan positions start, start+1, start+2, start+3 (mod 4).
  // The loop walks from the farthest position to the nearest, so the nearest
  // requesting index is the one written last.
  function automatic logic [2:0] f_arb(input logic [3:0] req_v, input logic [1:0] start);
    logic [1:0] idx;
    f_arb = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req_v[idx]) f_arb = {1'b1, idx};
    end
  endfunction

  assign w_s_inc = r_s + 2'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_s_nxt     = r_s;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;
    w_arb       = 3'b000;
    case (r_state)
      ST_IDLE: begin
        w_arb = f_arb(req, r_ptr);
        if (w_arb[2]) begin
          w_gnt_nxt   = 4'b0001 << w_arb[1:0];
          w_s_nxt     = w_arb[1:0];
          w_valid_nxt = 1'b1;
          w_hold_nxt  = 8'd0;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!req[r_s] || (r_hold_cnt == HOLD_LAST)) begin
          // The owner moves to the lowest priority. It is regranted only if it is the sole requester.
          w_ptr_nxt = w_s_inc;
          w_arb     = f_arb(req, w_s_inc);
          if (w_arb[2]) begin
            w_gnt_nxt  = 4'b0001 << w_arb[1:0];
            w_s_nxt    = w_arb[1:0];
            w_hold_nxt = 8'd0;
          end else begin
            // s keeps its last value after the release.
            w_gnt_nxt   = 4'b0000;
            w_valid_nxt = 1'b0;
            w_hold_nxt  = 8'd0;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= 4'b0000;
      r_s        <= 2'd0;
      r_valid    <= 1'b0;
      r_ptr      <= 2'd0;
      r_hold_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_s        <= w_s_nxt;
      r_valid    <= w_valid_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_valid && (r_s == 2'(i))) out = in[i*WIDTH +: WIDTH];
    end
  end

  assign gnt   = r_gnt;
  assign s     = r_s;
  assign valid = r_valid;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
module tb_rr_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] in_v;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] s_a, s_b;
  logic       valid_a, valid_b;
  logic [0:0] out_a, out_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];

  rr_mux4_arbiter #(.WIDTH(1), .MAX_HOLD(8)) dut_a (
    .clk(clk), .rst(rst), .req(req), .in(in_v),
    .gnt(gnt_a), .s(s_a), .valid(valid_a), .out(out_a)
  );

  rr_mux4_arbiter #(.WIDTH(1), .MAX_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .in(in_v),
    .gnt(gnt_b), .s(s_b), .valid(valid_b), .out(out_b)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pack(input logic [3:0] g, input logic [1:0] sel,
                                      input logic v, input logic o);
    return {g, sel, v, o};
  endfunction

  function automatic logic [3:0] onehot(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return one << idx;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [7:0] e);
    exp_t x;
    x.name = nm;
    x.exp  = e;
    sb_q.push_back(x);
  endtask

  task automatic test_reset;
    exp_t e;
    logic [7:0] act;
    rst  = 1'b1;
    req  = 4'b1111;
    in_v = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        rst = 1'b0;
        push("reset_release", pack(4'b0001, 2'd0, 1'b1, 1'b1));
      end else begin
        push($sformatf("reset_hold c=%0d", c), pack(4'b0000, 2'd0, 1'b0, 1'b0));
      end
      tick();
      e   = sb_q.pop_front();
      act = {gnt_a, s_a, valid_a, out_a[0]};
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s actual=%b expected=%b", e.name, act, e.exp);
      end
    end
  endtask

  task automatic test_rotation;
    exp_t e;
    logic [7:0] act;
    int owner;
    rst  = 1'b1;
    req  = 4'b1111;
    in_v = 4'b0101;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      owner = (k / 8) % 4;
      push($sformatf("rotate k=%0d", k), pack(onehot(owner), 2'(owner), 1'b1, in_v[owner]));
      tick();
      e   = sb_q.pop_front();
      act = {gnt_a, s_a, valid_a, out_a[0]};
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s actual=%b expected=%b", e.name, act, e.exp);
      end
    end
  endtask

  task automatic test_single;
    exp_t e;
    logic [7:0] act;
    rst  = 1'b1;
    req  = 4'b0001;
    in_v = 4'b0001;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      push($sformatf("single k=%0d", k), pack(4'b0001, 2'd0, 1'b1, 1'b1));
      tick();
      e   = sb_q.pop_front();
      act = {gnt_a, s_a, valid_a, out_a[0]};
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s actual=%b expected=%b", e.name, act, e.exp);
      end
    end
  endtask

  task automatic test_owner_drop;
    exp_t e;
    logic [7:0] act;
    logic [3:0] req_seq [6];
    logic [7:0] exp_seq [6];
    req_seq = '{4'b0100, 4'b0110, 4'b0110, 4'b0010, 4'b0010, 4'b0000};
    exp_seq = '{pack(4'b0100, 2'd2, 1'b1, 1'b1),
                pack(4'b0100, 2'd2, 1'b1, 1'b1),
                pack(4'b0100, 2'd2, 1'b1, 1'b1),
                pack(4'b0010, 2'd1, 1'b1, 1'b0),
                pack(4'b0010, 2'd1, 1'b1, 1'b0),
                pack(4'b0000, 2'd1, 1'b0, 1'b0)};
    rst  = 1'b1;
    req  = 4'b0000;
    in_v = 4'b0100;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      req = req_seq[k];
      push($sformatf("owner_drop k=%0d", k), exp_seq[k]);
      tick();
      e   = sb_q.pop_front();
      act = {gnt_a, s_a, valid_a, out_a[0]};
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s actual=%b expected=%b", e.name, act, e.exp);
      end
    end
  endtask

  task automatic test_max_hold1;
    exp_t e;
    logic [7:0] act;
    int owner;
    rst  = 1'b1;
    req  = 4'b1111;
    in_v = 4'b1010;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      owner = k % 4;
      if (k == 8) begin
        req = 4'b0000;
        push("hold1 drop", pack(4'b0000, 2'd3, 1'b0, 1'b0));
      end else begin
        push($sformatf("hold1 k=%0d", k), pack(onehot(owner), 2'(owner), 1'b1, in_v[owner]));
      end
      tick();
      e   = sb_q.pop_front();
      act = {gnt_b, s_b, valid_b, out_b[0]};
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s actual=%b expected=%b", e.name, act, e.exp);
      end
    end
  endtask

  task automatic test_reset_midgrant;
    exp_t e;
    logic [7:0] act;
    logic       rst_seq [7];
    logic [3:0] req_seq [7];
    logic [7:0] exp_seq [7];
    rst_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    req_seq = '{4'b0010, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1000, 4'b1000};
    exp_seq = '{pack(4'b0010, 2'd1, 1'b1, 1'b0),
                pack(4'b1000, 2'd3, 1'b1, 1'b1),
                pack(4'b1000, 2'd3, 1'b1, 1'b1),
                pack(4'b0000, 2'd0, 1'b0, 1'b0),
                pack(4'b0001, 2'd0, 1'b1, 1'b0),
                pack(4'b0000, 2'd0, 1'b0, 1'b0),
                pack(4'b1000, 2'd3, 1'b1, 1'b1)};
    rst  = 1'b1;
    req  = 4'b0000;
    in_v = 4'b1000;
    tick();
    for (int k = 0; k < 7; k++) begin
      rst = rst_seq[k];
      req = req_seq[k];
      push($sformatf("midgrant_reset k=%0d", k), exp_seq[k]);
      tick();
      e   = sb_q.pop_front();
      act = {gnt_a, s_a, valid_a, out_a[0]};
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s actual=%b expected=%b", e.name, act, e.exp);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    in_v = 4'b0000;
    test_reset();
    test_rotation();
    test_single();
    test_owner_drop();
    test_max_hold1();
    test_reset_midgrant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
